// File: rtl/feature_accum_sat_if.sv
// Handshake bundle between a feature source, feature_accum_sat and its downstream consumer.
// The slave modport is the accumulator's view; master is the driver/consumer view.
interface feature_accum_sat_if #(
    parameter int unsigned FEATURE_WIDTH = 32,
    parameter int unsigned LEN_WIDTH     = 10
);
    logic [LEN_WIDTH-1:0]     cfg_len;
    logic                     in_valid;
    logic                     in_ready;
    logic [FEATURE_WIDTH-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [FEATURE_WIDTH-1:0] out_data;
    logic                     out_sat;
    logic                     busy;

    modport master (
        output cfg_len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat, busy
    );

    modport slave (
        input  cfg_len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat, busy
    );
endinterface

// File: rtl/feature_accum_sat.sv
// Sums groups of cfg_len signed partial sums and emits one saturated result per group,
// with back-to-back groups and a single-entry output register.
module feature_accum_sat #(
    parameter int unsigned FEATURE_WIDTH = 32,
    parameter int unsigned LEN_WIDTH     = 10,
    parameter int unsigned ACC_WIDTH     = 48
) (
    input logic                clk,
    input logic                rst,
    feature_accum_sat_if.slave acc_bus
);
    logic [ACC_WIDTH-1:0]     r_acc;
    logic [LEN_WIDTH-1:0]     r_cnt;
    logic [LEN_WIDTH-1:0]     r_len;
    logic                     r_out_valid;
    logic [FEATURE_WIDTH-1:0] r_out_data;
    logic                     r_out_sat;

    logic                     w_in_ready;
    logic                     w_fire;
    logic                     w_first;
    logic [LEN_WIDTH-1:0]     w_len_eff;
    logic                     w_last;
    logic [ACC_WIDTH-1:0]     w_in_sext;
    logic [ACC_WIDTH-1:0]     w_sum;
    logic                     w_ovf_pos;
    logic                     w_ovf_neg;
    logic [FEATURE_WIDTH-1:0] w_clip;

    assign w_in_ready = !r_out_valid || acc_bus.out_ready;
    assign w_fire     = acc_bus.in_valid && w_in_ready;
    assign w_first    = (r_cnt == '0);

    // Length is taken live from cfg_len only on the first beat; later beats use the latched copy.
    always_comb begin
        w_len_eff = r_len;
        if (w_first) begin
            w_len_eff = (acc_bus.cfg_len == '0) ? LEN_WIDTH'(1) : acc_bus.cfg_len;
        end
    end

    assign w_last = w_fire &&
                    (({1'b0, r_cnt} + {{LEN_WIDTH{1'b0}}, 1'b1}) == {1'b0, w_len_eff});

    assign w_in_sext = {{(ACC_WIDTH-FEATURE_WIDTH){acc_bus.in_data[FEATURE_WIDTH-1]}},
                        acc_bus.in_data};
    assign w_sum     = w_first ? w_in_sext : (r_acc + w_in_sext);

    // Out of range when the bits above the output sign bit disagree with the accumulator sign.
    assign w_ovf_pos = !w_sum[ACC_WIDTH-1] && (|w_sum[ACC_WIDTH-2:FEATURE_WIDTH-1]);
    assign w_ovf_neg = w_sum[ACC_WIDTH-1] && !(&w_sum[ACC_WIDTH-2:FEATURE_WIDTH-1]);

    always_comb begin
        w_clip = w_sum[FEATURE_WIDTH-1:0];
        if (w_ovf_pos) begin
            w_clip = {1'b0, {(FEATURE_WIDTH-1){1'b1}}};
        end else if (w_ovf_neg) begin
            w_clip = {1'b1, {(FEATURE_WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_len       <= LEN_WIDTH'(1);
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            if (w_fire) begin
                r_acc <= w_sum;
                if (w_first) begin
                    r_len <= w_len_eff;
                end
                if (w_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + LEN_WIDTH'(1);
                end
            end

            if (w_last) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_clip;
                r_out_sat   <= w_ovf_pos || w_ovf_neg;
            end else if (r_out_valid && acc_bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign acc_bus.in_ready  = w_in_ready;
    assign acc_bus.out_valid = r_out_valid;
    assign acc_bus.out_data  = r_out_data;
    assign acc_bus.out_sat   = r_out_sat;
    assign acc_bus.busy      = (r_cnt != '0) || r_out_valid;
endmodule

// File: tb/tb_feature_accum_sat.sv
// Randomised scoreboard bench for feature_accum_sat: group sums are modelled with plain
// 64-bit arithmetic and checked by an independent output monitor.
module tb_feature_accum_sat;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    feature_accum_sat_if #(.FEATURE_WIDTH(32), .LEN_WIDTH(10)) bus ();

    feature_accum_sat #(
        .FEATURE_WIDTH(32),
        .LEN_WIDTH    (10),
        .ACC_WIDTH    (48)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .acc_bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [32:0] sb[$];          // {sat, data} of each expected result, oldest first
    int          m_cnt   = 0;    // beats accepted in the open group
    int          m_len   = 1;
    longint      m_sum   = 0;
    bit          m_ov    = 1'b0; // a result is held at the output
    int          rdy_pct = 100;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_accept(input logic [31:0] d, input logic [9:0] cfg, output bit pushed);
        logic [31:0] res;
        bit          sat;
        pushed = 1'b0;
        if (m_cnt == 0) begin
            m_len = (cfg == 0) ? 1 : int'(cfg);
            m_sum = 0;
        end
        m_sum += longint'($signed(d));
        m_cnt++;
        if (m_cnt == m_len) begin
            sat = 1'b1;
            if (m_sum > 64'sd2147483647) res = 32'h7FFF_FFFF;
            else if (m_sum < -64'sd2147483648) res = 32'h8000_0000;
            else begin
                res = m_sum[31:0];
                sat = 1'b0;
            end
            sb.push_back({sat, res});
            m_cnt  = 0;
            pushed = 1'b1;
        end
    endtask

    // One clock of stimulus; reports whether the input beat was accepted.
    task automatic cycle(input bit v, input logic [31:0] d, input logic [9:0] cfg,
                         input bit ordy, output bit acc);
        bit pushed;
        pushed = 1'b0;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.cfg_len   = cfg;
        bus.out_ready = ordy;
        #1;
        check("out_valid", longint'(bus.out_valid), longint'(m_ov));
        check("in_ready", longint'(bus.in_ready), longint'(!m_ov || ordy));
        check("busy", longint'(bus.busy), longint'((m_cnt != 0) || m_ov));
        acc = v && bus.in_ready;
        if (acc) model_accept(d, cfg, pushed);
        if (pushed) m_ov = 1'b1;
        else if (m_ov && ordy) m_ov = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic [9:0] cfg);
        bit a;
        int n;
        a = 1'b0;
        n = 0;
        while (!a && n < 100) begin
            cycle(1'b1, d, cfg, $urandom_range(99) < rdy_pct, a);
            n++;
        end
        check("beat_accepted", longint'(a), 1);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 10'd0, $urandom_range(99) < rdy_pct, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_data", longint'(bus.out_data), 0);
        check("rst_out_sat", longint'(bus.out_sat), 0);
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_in_ready", longint'(bus.in_ready), 1);
        rst   = 1'b0;
        m_cnt = 0;
        m_ov  = 1'b0;
        sb.delete();
    endtask

    // Output monitor: pops on every transfer, and checks output hold during stalls.
    initial begin
        logic [32:0] e;
        logic [32:0] prev;
        bit          stall;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stall = 1'b0;
            end else if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got %0h expected none at %0t",
                             bus.out_data, $time);
                end else begin
                    e = sb.pop_front();
                    check("out_data", longint'(bus.out_data), longint'(e[31:0]));
                    check("out_sat", longint'(bus.out_sat), longint'(e[32]));
                end
                stall = 1'b0;
            end else if (bus.out_valid) begin
                if (stall) check("stall_hold", longint'({bus.out_sat, bus.out_data}),
                                 longint'(prev));
                prev  = {bus.out_sat, bus.out_data};
                stall = 1'b1;
            end else begin
                stall = 1'b0;
            end
        end
    end

    initial begin
        bit a;
        logic [31:0] d;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.cfg_len   = '0;
        bus.out_ready = 1'b0;
        do_reset();

        // Four-term group, then positive and negative saturation.
        beat(32'd10, 10'd4);
        beat(32'd20, 10'd4);
        beat(-32'sd5, 10'd4);
        beat(32'd7, 10'd4);
        idle(2);
        beat(32'h7FFF_FFFF, 10'd2);
        beat(32'h0000_0010, 10'd2);
        idle(2);
        beat(32'h8000_0000, 10'd2);
        beat(32'hFFFF_FFFF, 10'd2);
        idle(2);

        // Single-term groups stream one result per cycle.
        for (int i = 1; i <= 5; i++) beat(i, 10'd1);
        idle(2);

        // Downstream stall with input pending, then release accepts the beat immediately.
        for (int i = 0; i < 3; i++) beat(32'd100 + i, 10'd3);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'd9, 10'd3, 1'b0, a);
        cycle(1'b1, 32'd9, 10'd3, 1'b1, a);
        check("release_accept", longint'(a), 1);
        beat(32'd1, 10'd3);
        beat(32'd1, 10'd3);
        idle(2);

        // Reset mid-group discards the partial sum.
        beat(32'd50, 10'd4);
        beat(32'd60, 10'd4);
        do_reset();
        beat(32'd3, 10'd2);
        beat(32'd4, 10'd2);
        idle(2);

        // Length change mid-group is ignored; zero length behaves as one.
        beat(32'd1, 10'd4);
        beat(32'd2, 10'd2);
        beat(32'd3, 10'd2);
        beat(32'd4, 10'd2);
        beat(32'd42, 10'd0);
        idle(2);

        // Random traffic with back-pressure, idles, extremes and occasional resets.
        for (int it = 0; it < 600; it++) begin
            rdy_pct = int'($urandom_range(100, 30));
            case ($urandom_range(9))
                0: d = 32'h7FFF_FFFF;
                1: d = 32'h8000_0000;
                2: d = 32'h4000_0000 + $urandom_range(255);
                default: d = $urandom;
            endcase
            if ($urandom_range(119) == 0) do_reset();
            else if ($urandom_range(5) == 0) idle(1);
            else beat(d, 10'($urandom_range(5)));
        end

        rdy_pct = 100;
        idle(4);
        check("scoreboard_empty", longint'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
